// File: rtl/mempipe_sched.sv
// Memory-pipe issue scheduler: picks one of NREQ requesters per cycle with
// round-robin fairness and a starvation override, then stages the winner into mm1.
package mempipe_pkg;
  typedef struct packed {
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [31:0] addr;
  } t_mempipe_arb;
endpackage

module mempipe_sched
  import mempipe_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int STARVE_THRESH = 8,
  localparam int SW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid_mm0,
  input  t_mempipe_arb      req_pkt_mm0 [NREQ],
  output logic [NREQ-1:0]   gnt_mm0,
  input  logic              pipe_stall_mm0,
  output logic              pipe_valid_mm0,
  output t_mempipe_arb      pipe_pkt_mm0,
  output logic              pipe_valid_mm1,
  output t_mempipe_arb      pipe_pkt_mm1,
  output logic [SW-1:0]     pipe_src_mm1,
  output logic              starve_any
);

  localparam int CW = $clog2(STARVE_THRESH + 1);
  localparam logic [CW-1:0] THRESH = CW'(STARVE_THRESH);

  logic [SW-1:0]   rr_ptr_r;
  logic [CW-1:0]   cnt_r [NREQ];
  logic [NREQ-1:0] starve_vec_s;
  logic [SW-1:0]   win_s;
  logic            found_s;

  // Per-requester starvation flags
  always_comb begin
    starve_vec_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      starve_vec_s[i] = (cnt_r[i] == THRESH);
    end
    starve_any = |starve_vec_s;
  end

  // Winner selection; loops run high-to-low so the last hit is the preferred index
  always_comb begin : sel_p
    logic [SW:0] j;
    found_s = 1'b0;
    win_s   = '0;
    j       = '0;
    if (pipe_stall_mm0) begin
      found_s = 1'b0;
    end else if (|(req_valid_mm0 & starve_vec_s)) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        found_s = found_s | (req_valid_mm0[i] & starve_vec_s[i]);
        win_s   = (req_valid_mm0[i] && starve_vec_s[i]) ? SW'(i) : win_s;
      end
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        j       = {1'b0, rr_ptr_r} + (SW+1)'(k);
        j       = (j >= (SW+1)'(NREQ)) ? (j - (SW+1)'(NREQ)) : j;
        found_s = found_s | req_valid_mm0[j];
        win_s   = req_valid_mm0[j] ? SW'(j) : win_s;
      end
    end
  end

  // mm0 outputs driven straight from the selection
  always_comb begin
    gnt_mm0        = found_s ? (NREQ'(1) << win_s) : '0;
    pipe_valid_mm0 = found_s;
    pipe_pkt_mm0   = found_s ? req_pkt_mm0[win_s] : '0;
  end

  // Arbitration state and mm1 staging; reset overrides every update
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r       <= '0;
      pipe_valid_mm1 <= 1'b0;
      pipe_pkt_mm1   <= '0;
      pipe_src_mm1   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      if (found_s) begin
        rr_ptr_r <= (win_s == SW'(NREQ - 1)) ? '0 : (win_s + SW'(1));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      pipe_valid_mm1 <= pipe_valid_mm0;
      pipe_pkt_mm1   <= pipe_pkt_mm0;
      pipe_src_mm1   <= win_s;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid_mm0[i] || gnt_mm0[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] != THRESH) begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

`ifndef SYNTHESIS
  mempipe_sched_chk #(.NREQ(NREQ)) u_chk (
    .clk           (clk),
    .req_valid_mm0 (req_valid_mm0),
    .gnt_mm0       (gnt_mm0)
  );
`endif

endmodule

// Grant legality: at most one grant, and only to an active requester.
module mempipe_sched_chk #(
  parameter int NREQ = 3
) (
  input logic            clk,
  input logic [NREQ-1:0] req_valid_mm0,
  input logic [NREQ-1:0] gnt_mm0
);
  a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_mm0));
  a_gnt_has_req: assert property (@(posedge clk) (gnt_mm0 & ~req_valid_mm0) == '0);
endmodule

// File: doc/mempipe_sched.md
MEMPIPE_SCHED -- requirements
Module: mempipe_sched

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of mem-pipe requesters (0=LDQ, 1=STQ, 2=fill buffer).
REQ-002 SHALL have parameter STARVE_THRESH, default 8, consecutive lost cycles before a requester is forced to win.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid_mm0  input  NREQ  per-requester request valid.
REQ-007 req_pkt_mm0  input  NREQ x t_mempipe_arb (unpacked array)  per-requester request packet.
REQ-008 gnt_mm0  output  NREQ  one-hot-or-zero grant, same cycle as request.
REQ-009 pipe_stall_mm0  input  1  mem pipe cannot accept a new op this cycle.
REQ-010 pipe_valid_mm0  output  1  an op enters the pipe this cycle.
REQ-011 pipe_pkt_mm0  output  t_mempipe_arb  packet of the granted requester.
REQ-012 pipe_valid_mm1  output  1  registered copy of pipe_valid_mm0.
REQ-013 pipe_pkt_mm1  output  t_mempipe_arb  registered copy of pipe_pkt_mm0.
REQ-014 pipe_src_mm1  output  $clog2(NREQ)  index of the requester that won in mm0, registered.
REQ-015 starve_any  output  1  some requester's counter is at STARVE_THRESH.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt_mm0 is combinational from current inputs and state (zero-cycle grant latency).
REQ-017 SHALL assert no grant when pipe_stall_mm0=1; pipe_valid_mm0=0 in that cycle.
REQ-018 Starvation override: if any requesting index has counter == STARVE_THRESH, SHALL grant the lowest such index.
REQ-019 Otherwise round-robin: SHALL grant the first requesting index at or after rr_ptr, wrapping from NREQ-1 to 0.
REQ-020 On any grant to index i, rr_ptr SHALL update to (i+1) mod NREQ next cycle; with no grant rr_ptr SHALL hold.
REQ-021 Per-requester counter, width $clog2(STARVE_THRESH+1): cleared when granted or not requesting; incremented when requesting and not granted (stall cycles included); saturates at STARVE_THRESH.
REQ-022 pipe_valid_mm0 = |gnt_mm0; pipe_pkt_mm0 = req_pkt_mm0 of the winner, don't-care (drive '0) when no grant.
REQ-023 mm1 stage SHALL register pipe_valid_mm0, pipe_pkt_mm0 and winner index every cycle (1-cycle latency, no enable).
REQ-024 Requester drops req_valid without a grant: SHALL be legal; its counter clears.
REQ-025 starve_any SHALL be combinational OR over (counter == STARVE_THRESH).
REQ-026 SHALL contain no simulation-only logic affecting outputs; SIMULATION-guarded grant trace allowed.

Reset
REQ-027 On reset: rr_ptr=0, all counters=0, pipe_valid_mm1=0, pipe_pkt_mm1='0, pipe_src_mm1=0.
REQ-028 Reset asserted mid-stream SHALL take priority over all updates in that cycle; gnt_mm0 stays combinational but next-cycle state is the reset state.
REQ-029 Assertion: gnt_mm0 SHALL be $onehot0 every cycle and never set for an index with req_valid_mm0=0.

Verification
REQ-030 All three requesting continuously, no stall, from reset -> grants 0,1,2,0,1,2...; pipe_src_mm1 lags gnt by one cycle.
REQ-031 Only requester 1 requests for 4 cycles -> gnt_mm0=3'b010 each cycle, rr_ptr=2 after first grant.
REQ-032 All request, pipe_stall_mm0=1 for 8 cycles -> no grants, all counters=8, starve_any=1; stall drops -> grant index 0, then 1, then 2 (override, lowest first).
REQ-033 Req 0 and 2 only, rr_ptr=1 -> grant 2 first, then 0, alternating.
REQ-034 Reset pulsed while counters=5 and pipe_valid_mm1=1 -> next cycle counters=0, rr_ptr=0, pipe_valid_mm1=0.
REQ-035 Requester 0 requests 3 cycles while losing, drops 1 cycle, re-requests -> counter restarts from 0, no premature override.
